// File: rtl/cmp_pkg.sv
// Shared definitions for the iterative comparator: function_select bit
// positions and the control state encoding.
package cmp_pkg;

  localparam int FS_MINMAX = 3;
  localparam int FS_LESS   = 2;
  localparam int FS_USIGN  = 1;
  localparam int FS_NEGATE = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cmp_step.sv
// One chunk of the iterative compare: unsigned less-than and equality of two
// STEP-bit slices.
module cmp_step #(
  parameter int STEP = 8
) (
  input  logic [STEP-1:0] a_chunk,
  input  logic [STEP-1:0] b_chunk,
  output logic            chunk_lt,
  output logic            chunk_eq
);

  assign chunk_lt = a_chunk < b_chunk;
  assign chunk_eq = a_chunk == b_chunk;

endmodule

// File: rtl/cmp_iter.sv
// Multi-cycle comparator: walks the operands STEP bits per cycle, MSB chunk
// first, and reports the branch condition bit or a min/max value.
module cmp_iter
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int STEP       = 8,
  parameter int EARLY_EXIT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic [3:0]       function_select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             result,
  output logic [WIDTH-1:0] result_value
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]    LAST = CW'(N - 1);
  localparam logic [WIDTH-1:0] BIAS = WIDTH'(1) << (WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             decided_q, decided_d;
  logic             lt_q, lt_d;
  logic             out_valid_q, out_valid_d;
  logic             result_q, result_d;
  logic [WIDTH-1:0] result_value_q, result_value_d;
  logic [WIDTH-1:0] wa_q, wa_d, wb_q, wb_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       fs_q, fs_d;

  logic accept;
  logic step_lt, step_eq;
  logic fin_eq;

  cmp_step #(.STEP(STEP)) u_step (
    .a_chunk  (wa_q[WIDTH-1 -: STEP]),
    .b_chunk  (wb_q[WIDTH-1 -: STEP]),
    .chunk_lt (step_lt),
    .chunk_eq (step_eq)
  );

  assign in_ready     = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept       = in_valid && in_ready;
  assign out_valid    = out_valid_q;
  assign result       = result_q;
  assign result_value = result_value_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    decided_d      = decided_q;
    lt_d           = lt_q;
    out_valid_d    = out_valid_q;
    result_d       = result_q;
    result_value_d = result_value_q;
    wa_d           = wa_q;
    wb_d           = wb_q;
    a_d            = a_q;
    b_d            = b_q;
    fs_d           = fs_q;
    fin_eq         = 1'b0;

    case (state_q)
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        wa_d  = wa_q << STEP;
        wb_d  = wb_q << STEP;
        if (!decided_q && !step_eq) begin
          decided_d = 1'b1;
          lt_d      = step_lt;
        end
        if (cnt_q == LAST || (EARLY_EXIT != 0 && decided_d)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          fin_eq      = !decided_d;
          if (fs_q[FS_MINMAX]) begin
            result_d = lt_d;
            // lt selects A for min; negate flips to max. Ties fall to A.
            if (fs_q[FS_NEGATE]) result_value_d = lt_d ? b_q : a_q;
            else                 result_value_d = lt_d ? a_q : b_q;
          end else begin
            result_d       = (fs_q[FS_LESS] ? lt_d : fin_eq) ^ fs_q[FS_NEGATE];
            result_value_d = '0;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: ;
    endcase

    // Loading overrides whatever DONE decided, giving the zero-bubble handoff.
    if (accept) begin
      state_d   = RUN;
      cnt_d     = '0;
      decided_d = 1'b0;
      lt_d      = 1'b0;
      a_d       = input_a;
      b_d       = input_b;
      fs_d      = function_select;
      wa_d      = function_select[FS_USIGN] ? input_a : (input_a ^ BIAS);
      wb_d      = function_select[FS_USIGN] ? input_b : (input_b ^ BIAS);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      decided_q      <= 1'b0;
      lt_q           <= 1'b0;
      out_valid_q    <= 1'b0;
      result_q       <= 1'b0;
      result_value_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      decided_q      <= decided_d;
      lt_q           <= lt_d;
      out_valid_q    <= out_valid_d;
      result_q       <= result_d;
      result_value_q <= result_value_d;
    end
  end

  // Operand storage needs no reset; it is always loaded before use.
  always_ff @(posedge clk) begin
    wa_q <= wa_d;
    wb_q <= wb_d;
    a_q  <= a_d;
    b_q  <= b_d;
    fs_q <= fs_d;
  end

endmodule

// File: tb/tb_cmp_iter.sv
// Directed bench for cmp_iter: one full-latency instance and one early-exit
// instance sharing clock, reset and operand buses.
module tb_cmp_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] input_a, input_b;
  logic [3:0]  function_select;
  logic        out_ready;
  logic        in_valid0, in_ready0, out_valid0, result0;
  logic [31:0] result_value0;
  logic        in_valid1, in_ready1, out_valid1, result1;
  logic [31:0] result_value1;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  cmp_iter #(.WIDTH(32), .STEP(8), .EARLY_EXIT(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
    .input_a(input_a), .input_b(input_b), .function_select(function_select),
    .out_valid(out_valid0), .out_ready(out_ready), .result(result0),
    .result_value(result_value0)
  );

  cmp_iter #(.WIDTH(32), .STEP(8), .EARLY_EXIT(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .input_a(input_a), .input_b(input_b), .function_select(function_select),
    .out_valid(out_valid1), .out_ready(out_ready), .result(result1),
    .result_value(result_value1)
  );

  // Issue one operation, count edges from accept to out_valid, then let the
  // result drain (out_ready is 1).
  task automatic do_op(input logic ee, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] fs, output logic r, output logic [31:0] v,
                       output int lat);
    input_a = a; input_b = b; function_select = fs; out_ready = 1'b1;
    if (ee) in_valid1 = 1'b1; else in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0; in_valid1 = 1'b0;
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if ((ee ? out_valid1 : out_valid0) === 1'b1) begin
        lat = i;
        break;
      end
    end
    r = ee ? result1 : result0;
    v = ee ? result_value1 : result_value0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(posedge clk); #1;
    nvec++;
    if (in_ready0 !== 1'b1) begin nerr++; $display("FAIL rst_in_ready got %b want 1", in_ready0); end
    nvec++;
    if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
      nerr++; $display("FAIL rst_out_valid got %b/%b want 0/0", out_valid0, out_valid1);
    end
    nvec++;
    if (result0 !== 1'b0 || result_value0 !== 32'h0) begin
      nerr++; $display("FAIL rst_result got %b/%h want 0/00000000", result0, result_value0);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_signed;
    logic r; logic [31:0] v; int lat;
    do_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0100, r, v, lat);
    nvec++;
    if (r !== 1'b1) begin nerr++; $display("FAIL signed_lt got %b want 1", r); end
    nvec++;
    if (lat != 4) begin nerr++; $display("FAIL signed_latency got %0d want 4", lat); end
    do_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0110, r, v, lat);
    nvec++;
    if (r !== 1'b0) begin nerr++; $display("FAIL unsigned_lt got %b want 0", r); end
    nvec++;
    if (v !== 32'h0) begin nerr++; $display("FAIL cond_value got %h want 00000000", v); end
  endtask

  task automatic test_equal;
    logic r; logic [31:0] v; int lat;
    do_op(1'b0, 32'h1234_5678, 32'h1234_5678, 4'b0000, r, v, lat);
    nvec++;
    if (r !== 1'b1) begin nerr++; $display("FAIL eq got %b want 1", r); end
    do_op(1'b0, 32'h1234_5678, 32'h1234_5678, 4'b0001, r, v, lat);
    nvec++;
    if (r !== 1'b0) begin nerr++; $display("FAIL ne got %b want 0", r); end
    do_op(1'b0, 32'h1234_5678, 32'h1234_5678, 4'b0101, r, v, lat);
    nvec++;
    if (r !== 1'b1) begin nerr++; $display("FAIL ge got %b want 1", r); end
    do_op(1'b0, 32'h1234_5678, 32'h1234_5679, 4'b0000, r, v, lat);
    nvec++;
    if (r !== 1'b0) begin nerr++; $display("FAIL eq_lsb_diff got %b want 0", r); end
  endtask

  task automatic test_minmax;
    logic r; logic [31:0] v; int lat;
    do_op(1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 4'b1000, r, v, lat);
    nvec++;
    if (v !== 32'h8000_0000) begin nerr++; $display("FAIL min_signed got %h want 80000000", v); end
    nvec++;
    if (r !== 1'b1) begin nerr++; $display("FAIL min_signed_lt got %b want 1", r); end
    do_op(1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 4'b1001, r, v, lat);
    nvec++;
    if (v !== 32'h7FFF_FFFF) begin nerr++; $display("FAIL max_signed got %h want 7fffffff", v); end
    do_op(1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 4'b1010, r, v, lat);
    nvec++;
    if (v !== 32'h7FFF_FFFF) begin nerr++; $display("FAIL min_unsigned got %h want 7fffffff", v); end
    do_op(1'b0, 32'hAAAA_0000, 32'hAAAA_0000, 4'b1001, r, v, lat);
    nvec++;
    if (v !== 32'hAAAA_0000 || r !== 1'b0) begin
      nerr++; $display("FAIL minmax_tie got %h/%b want aaaa0000/0", v, r);
    end
  endtask

  task automatic test_back_to_back;
    logic hold_r; logic [31:0] hold_v; int lat;
    input_a = 32'd5; input_b = 32'd9; function_select = 4'b0100;
    out_ready = 1'b0; in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid0 === 1'b1) begin lat = i; break; end
    end
    nvec++;
    if (lat != 4 || result0 !== 1'b1) begin
      nerr++; $display("FAIL bp_first got lat %0d r %b want 4/1", lat, result0);
    end
    hold_r = result0; hold_v = result_value0;
    input_a = 32'd9; input_b = 32'd5; function_select = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      nvec++;
      if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0 || result0 !== hold_r ||
          result_value0 !== hold_v) begin
        nerr++;
        $display("FAIL bp_hold cyc %0d got v%b rdy%b r%b want v1 rdy0 r%b",
                 i, out_valid0, in_ready0, result0, hold_r);
      end
    end
    input_a = 32'd9; input_b = 32'd5; function_select = 4'b0100;
    in_valid0 = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    nvec++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b0) begin
      nerr++; $display("FAIL handoff got v%b rdy%b want v0 rdy0 (running)", out_valid0, in_ready0);
    end
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid0 === 1'b1) begin lat = i; break; end
    end
    nvec++;
    if (lat != 4 || result0 !== 1'b0) begin
      nerr++; $display("FAIL b2b_second got lat %0d r %b want 4/0", lat, result0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_early_exit;
    logic r; logic [31:0] v; int lat;
    do_op(1'b1, 32'h0100_0000, 32'h0200_0000, 4'b0100, r, v, lat);
    nvec++;
    if (lat != 1 || r !== 1'b1) begin nerr++; $display("FAIL ee_chunk0 got lat %0d r %b want 1/1", lat, r); end
    do_op(1'b1, 32'h0001_0000, 32'h0002_0000, 4'b0100, r, v, lat);
    nvec++;
    if (lat != 2 || r !== 1'b1) begin nerr++; $display("FAIL ee_chunk1 got lat %0d r %b want 2/1", lat, r); end
    do_op(1'b1, 32'h0000_0002, 32'h0000_0001, 4'b0100, r, v, lat);
    nvec++;
    if (lat != 4 || r !== 1'b0) begin nerr++; $display("FAIL ee_chunk3 got lat %0d r %b want 4/0", lat, r); end
    do_op(1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b0000, r, v, lat);
    nvec++;
    if (lat != 4 || r !== 1'b1) begin nerr++; $display("FAIL ee_equal got lat %0d r %b want 4/1", lat, r); end
  endtask

  task automatic test_reset_mid_run;
    logic r; logic [31:0] v; int lat;
    input_a = 32'd1; input_b = 32'd2; function_select = 4'b0100;
    out_ready = 1'b1; in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    nvec++;
    if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
      nerr++; $display("FAIL midrst_async got rdy%b v%b want rdy1 v0", in_ready0, out_valid0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      nvec++;
      if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin
        nerr++; $display("FAIL midrst_idle cyc %0d got v%b rdy%b want v0 rdy1", i, out_valid0, in_ready0);
      end
    end
    do_op(1'b0, 32'h0000_0003, 32'h0000_0007, 4'b0110, r, v, lat);
    nvec++;
    if (lat != 4 || r !== 1'b1) begin nerr++; $display("FAIL midrst_next got lat %0d r %b want 4/1", lat, r); end
  endtask

  initial begin
    reset = 1'b1; in_valid0 = 1'b0; in_valid1 = 1'b0; out_ready = 1'b1;
    input_a = '0; input_b = '0; function_select = '0;
    #2;
    test_reset();
    test_signed();
    test_equal();
    test_minmax();
    test_back_to_back();
    test_early_exit();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d vectors", nvec);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cmp_iter.md
# cmp_iter

Parametrised, multi-cycle comparator for area-constrained builds of the core. It compares two WIDTH-bit operands STEP bits per cycle, MSB chunk first, behind a valid/ready handshake. It produces the branch-condition bit (eq/ne/lt/ge, signed/unsigned) and a min/max result value. It sits beside the ALU/branch path and replaces the single-cycle comparator where a WIDTH-bit magnitude comparator is too large.

## Interface
- WIDTH, 32: operand width; must be a multiple of STEP.
- STEP, 8: bits compared per cycle, ≥1; N = WIDTH/STEP chunks.
- EARLY_EXIT, 0: when 1, finish as soon as a chunk differs.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and function valid.
- in_ready  out  1  block can accept.
- input_a  in  WIDTH  operand A.
- input_b  in  WIDTH  operand B.
- function_select  in  4  bit3 minmax, bit2 less, bit1 usign, bit0 negate.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- result  out  1  condition bit.
- result_value  out  WIDTH  min/max value, 0 when minmax=0.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE→RUN on accept.
  - RUN→DONE after chunk N-1, or after the first differing chunk when EARLY_EXIT=1.
  - DONE→IDLE on out_ready, or DONE→RUN if a new accept happens in the same cycle.
- Accept condition: in_valid && in_ready. in_ready = (state==IDLE) || (state==DONE && out_ready).
- On accept, latch copies of A and B and the function bits. Load working shift registers with A and B; when usign=0, invert their bit WIDTH-1 (bias), so signed order equals unsigned order.
- Each RUN cycle compares the top STEP bits of the working registers, provided no difference has been found yet:
  - chunks differ: record lt = (a_chunk < b_chunk) and set the decided flag;
  - chunks equal: shift both registers left by STEP.
  - Once decided, later chunks are ignored.
- Final flags: eq = !decided; lt as recorded (0 if equal).
- Condition bit when minmax=0: q = less ? lt : eq; result = q ^ negate.
- Min/max when minmax=1:
  - result = lt (A below B);
  - result_value = negate ? (lt ? B : A) : (lt ? A : B). negate=0 gives min, negate=1 gives max; usign selects the ordering.
  - Equal operands give A.
- Outputs are registered. They are written on entry to DONE and held stable while out_valid && !out_ready.
- An in_valid that is not accepted has no effect. Operand inputs are sampled only on the accept edge.

## Timing
- Reset values: state IDLE, out_valid 0, result 0, result_value 0, chunk counter 0, decided 0. in_ready is 1 while in reset.
- Latency with EARLY_EXIT=0 is fixed: out_valid rises N edges after the accept edge (N=4 for the defaults).
- Latency with EARLY_EXIT=1: k+1 edges when chunk k (0-based, MSB first) is the first difference; N edges when the operands are equal.
- N=1 (STEP=WIDTH): single RUN cycle, so latency is 1.
- Back-to-back throughput: one result per N+1 cycles at most. The DONE handoff with out_ready=1 and a new accept costs no idle cycle.
- Reset asserted mid-RUN or in DONE: the operation is aborted with no output, and the pending result is discarded.
- Chunk counter width is clog2(N) with a minimum of 1. It wraps to 0 on each accept.

## Structure
- Shared package cmp_pkg holds:
  - function_select bit index constants (FS_MINMAX=3, FS_LESS=2, FS_USIGN=1, FS_NEGATE=0);
  - the state enum (IDLE, RUN, DONE).
- Sub-module cmp_step is combinational. It takes two STEP-bit chunks and outputs chunk_lt and chunk_eq. It is instantiated once in cmp_iter.

## Test plan
- Signed compare: A=0xFFFFFFFF, B=0x00000001, fs=0b0100 → result 1 with out_valid exactly 4 edges after accept. The same operands with fs=0b0110 (unsigned) → result 0.
- Equality: A=B=0x12345678, fs=0b0000 → result 1. fs=0b0001 → 0. fs=0b0101 → 1 (ge).
- Min/max: A=0x80000000, B=0x7FFFFFFF. fs=0b1000 → result_value 0x80000000. fs=0b1001 → 0x7FFFFFFF. fs=0b1010 → 0x7FFFFFFF.
- Backpressure and back-to-back: hold out_ready=0 for 5 cycles → outputs stable and in_ready=0. Then raise out_ready with in_valid=1 → handoff with no idle cycle, and the second result is correct.
- EARLY_EXIT=1: A=0x01000000, B=0x02000000 → out_valid 1 edge after accept, result 1 for lt. Equal operands → 4 edges.
- Reset pulse during RUN: out_valid stays 0, state returns to IDLE, and in_ready is 1 after reset releases. The next operation completes normally.
